// File: rtl/axis_mux_pkt_if.sv
// axis_mux_pkt_if: AXI-Stream bundle of N lanes, each W bits wide.
// The mux uses a NUM_CH-lane slave view on its input and a 1-lane master view on its output.
interface axis_mux_pkt_if #(
    parameter int N = 1,
    parameter int W = 256
);
    logic [N-1:0]   tvalid;
    logic [N-1:0]   tready;
    logic [N-1:0]   tlast;
    logic [N*W-1:0] tdata;
    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_mux_pkt.sv
// axis_mux_pkt: N-to-1 AXI-Stream mux that changes source only between packets.
// The output is one registered stage with full throughput and backpressure.
module axis_mux_pkt #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 256,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             reset,
    axis_mux_pkt_if.slave    s_axis,
    axis_mux_pkt_if.master   m_axis,
    input  logic [SEL_W-1:0] sel_in,
    output logic [SEL_W-1:0] active_sel,
    output logic             busy,
    output logic             sel_err
);
    typedef enum logic {IDLE, PKT} state_t;
    state_t            r_state;
    logic [SEL_W-1:0]  r_sel_q;
    logic [SEL_W-1:0]  r_active_sel;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              w_load_en;
    logic              w_switch;
    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic [DATA_W-1:0] w_data;
    always_comb begin
        sel_err   = {1'b0, r_sel_q} >= (SEL_W+1)'(NUM_CH);
        w_load_en = !r_tvalid || m_axis.tready[0];
        w_switch  = (r_state == IDLE) && (r_sel_q != r_active_sel) && !sel_err;
        // Gating with reset keeps every source from handshaking while reset is held.
        w_ready   = reset && w_load_en && !w_switch;
        w_accept  = w_ready && s_axis.tvalid[r_active_sel];
        w_data    = s_axis.tdata[DATA_W*int'(r_active_sel) +: DATA_W];
        w_last    = s_axis.tlast[r_active_sel];
    end
    assign s_axis.tready = w_ready ? NUM_CH'(1) << r_active_sel : '0;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign active_sel    = r_active_sel;
    assign busy          = r_state == PKT;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sel_q      <= '0;
            r_active_sel <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
        end else begin
            r_sel_q <= sel_in;
            if (w_accept) begin
                r_tdata  <= w_data;
                r_tlast  <= w_last;
                r_tvalid <= 1'b1;
            end else if (m_axis.tready[0]) begin
                r_tvalid <= 1'b0;
            end
            if (w_switch)
                r_active_sel <= r_sel_q;
            // A switch never coincides with an accept, so accept alone drives the packet state.
            if (w_accept)
                r_state <= w_last ? IDLE : PKT;
        end
    end
endmodule

// File: tb/tb_axis_mux_pkt.sv
// tb_axis_mux_pkt: table-driven checks of a 4-channel mux plus hand sequences
// for asynchronous reset mid-packet and out-of-range select on a 3-channel mux.
module tb_axis_mux_pkt;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axis_mux_pkt_if #(.N(4), .W(DW)) s4 ();
    axis_mux_pkt_if #(.N(1), .W(DW)) m4 ();
    axis_mux_pkt_if #(.N(3), .W(DW)) s3 ();
    axis_mux_pkt_if #(.N(1), .W(DW)) m3 ();
    logic [1:0] sel4, act4, sel3, act3;
    logic       busy4, err4, busy3, err3;

    axis_mux_pkt #(.NUM_CH(4), .DATA_W(DW)) u4 (
        .clk(clk), .reset(reset), .s_axis(s4), .m_axis(m4),
        .sel_in(sel4), .active_sel(act4), .busy(busy4), .sel_err(err4));
    axis_mux_pkt #(.NUM_CH(3), .DATA_W(DW)) u3 (
        .clk(clk), .reset(reset), .s_axis(s3), .m_axis(m3),
        .sel_in(sel3), .active_sel(act3), .busy(busy3), .sel_err(err3));

    typedef struct packed {
        logic [3:0]  vld;
        logic        lst;
        logic [27:0] dat;
        logic [1:0]  sel;
        logic        mrdy;
        logic [3:0]  e_srdy;
        logic [1:0]  e_act;
        logic        e_busy;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
    } vec_t;
    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic [3:0] vld, logic lst, logic [27:0] dat, logic [1:0] sel,
                                logic mrdy, logic [3:0] e_srdy, logic [1:0] e_act, logic e_busy,
                                logic e_mv, logic [31:0] e_md, logic e_ml);
        mk = '{vld, lst, dat, sel, mrdy, e_srdy, e_act, e_busy, e_mv, e_md, e_ml};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lane i carries {i, dat} so a wrongly routed channel shows in the top nibble.
    task automatic drive4(input logic [3:0] vld, input logic lst, input logic [27:0] dat);
        s4.tvalid = vld;
        s4.tlast  = {4{lst}};
        for (int i = 0; i < 4; i++) s4.tdata[i*DW +: DW] = {4'(i), dat};
    endtask

    task automatic drive3(input logic [2:0] vld, input logic [27:0] dat);
        s3.tvalid = vld;
        s3.tlast  = 3'b111;
        for (int i = 0; i < 3; i++) s3.tdata[i*DW +: DW] = {4'(i), dat};
    endtask

    task automatic run(input vec_t v, input int idx);
        @(negedge clk);
        sel4 = v.sel;
        m4.tready = v.mrdy;
        drive4(v.vld, v.lst, v.dat);
        #1;
        chk($sformatf("v%0d s_tready", idx), 64'(s4.tready), 64'(v.e_srdy));
        chk($sformatf("v%0d active_sel", idx), 64'(act4), 64'(v.e_act));
        chk($sformatf("v%0d busy", idx), 64'(busy4), 64'(v.e_busy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d m_tvalid", idx), 64'(m4.tvalid), 64'(v.e_mv));
        chk($sformatf("v%0d m_tdata", idx), 64'(m4.tdata), 64'(v.e_md));
        chk($sformatf("v%0d m_tlast", idx), 64'(m4.tlast), 64'(v.e_ml));
    endtask

    initial begin
        sel4 = 2'd0;
        sel3 = 2'd0;
        m4.tready = 1'b1;
        m3.tready = 1'b1;
        drive4(4'b0, 1'b0, 28'h0);
        drive3(3'b0, 28'h0);
        // Basic 4-beat packet on ch0
        tbl.push_back(mk(4'b0001, 0, 28'hA0, 0, 1, 4'b0001, 0, 0, 1, 32'h000000A0, 0));
        tbl.push_back(mk(4'b0001, 0, 28'hA1, 0, 1, 4'b0001, 0, 1, 1, 32'h000000A1, 0));
        tbl.push_back(mk(4'b0001, 0, 28'hA2, 0, 1, 4'b0001, 0, 1, 1, 32'h000000A2, 0));
        tbl.push_back(mk(4'b0001, 1, 28'hA3, 0, 1, 4'b0001, 0, 1, 1, 32'h000000A3, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 0, 1, 4'b0001, 0, 0, 0, 32'h000000A3, 1));
        // 8-beat packet on ch0, request for ch2 arrives mid-packet
        tbl.push_back(mk(4'b0101, 0, 28'hB0, 0, 1, 4'b0001, 0, 0, 1, 32'h000000B0, 0));
        tbl.push_back(mk(4'b0101, 0, 28'hB1, 0, 1, 4'b0001, 0, 1, 1, 32'h000000B1, 0));
        tbl.push_back(mk(4'b0101, 0, 28'hB2, 0, 1, 4'b0001, 0, 1, 1, 32'h000000B2, 0));
        tbl.push_back(mk(4'b0101, 0, 28'hB3, 2, 1, 4'b0001, 0, 1, 1, 32'h000000B3, 0));
        tbl.push_back(mk(4'b0101, 0, 28'hB4, 2, 1, 4'b0001, 0, 1, 1, 32'h000000B4, 0));
        tbl.push_back(mk(4'b0101, 0, 28'hB5, 2, 1, 4'b0001, 0, 1, 1, 32'h000000B5, 0));
        tbl.push_back(mk(4'b0101, 0, 28'hB6, 2, 1, 4'b0001, 0, 1, 1, 32'h000000B6, 0));
        tbl.push_back(mk(4'b0101, 1, 28'hB7, 2, 1, 4'b0001, 0, 1, 1, 32'h000000B7, 1));
        tbl.push_back(mk(4'b0101, 1, 28'hC0, 2, 1, 4'b0000, 0, 0, 0, 32'h000000B7, 1));
        tbl.push_back(mk(4'b0101, 1, 28'hC0, 2, 1, 4'b0100, 2, 0, 1, 32'h200000C0, 1));
        // Switch to ch1, then backpressure 1,0,0,1
        tbl.push_back(mk(4'b0000, 0, 28'h00, 1, 1, 4'b0100, 2, 0, 0, 32'h200000C0, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 1, 1, 4'b0000, 2, 0, 0, 32'h200000C0, 1));
        tbl.push_back(mk(4'b0010, 0, 28'hE0, 1, 1, 4'b0010, 1, 0, 1, 32'h100000E0, 0));
        tbl.push_back(mk(4'b0010, 0, 28'hE1, 1, 0, 4'b0000, 1, 1, 1, 32'h100000E0, 0));
        tbl.push_back(mk(4'b0010, 0, 28'hE1, 1, 0, 4'b0000, 1, 1, 1, 32'h100000E0, 0));
        tbl.push_back(mk(4'b0010, 0, 28'hE1, 1, 1, 4'b0010, 1, 1, 1, 32'h100000E1, 0));
        tbl.push_back(mk(4'b0010, 1, 28'hE2, 1, 1, 4'b0010, 1, 1, 1, 32'h100000E2, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 1, 1, 4'b0010, 1, 0, 0, 32'h100000E2, 1));
        // Idle switch 1->0, then 0->3 with its bubble
        tbl.push_back(mk(4'b0000, 0, 28'h00, 0, 1, 4'b0010, 1, 0, 0, 32'h100000E2, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 0, 1, 4'b0000, 1, 0, 0, 32'h100000E2, 1));
        tbl.push_back(mk(4'b1000, 1, 28'hF0, 3, 1, 4'b0001, 0, 0, 0, 32'h100000E2, 1));
        tbl.push_back(mk(4'b1000, 1, 28'hF0, 3, 1, 4'b0000, 0, 0, 0, 32'h100000E2, 1));
        tbl.push_back(mk(4'b1000, 1, 28'hF0, 3, 1, 4'b1000, 3, 0, 1, 32'h300000F0, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 3, 1, 4'b1000, 3, 0, 0, 32'h300000F0, 1));
        // Move to ch2 and start a 5-beat packet (reset follows row 32)
        tbl.push_back(mk(4'b0000, 0, 28'h00, 2, 1, 4'b1000, 3, 0, 0, 32'h300000F0, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 2, 1, 4'b0000, 3, 0, 0, 32'h300000F0, 1));
        tbl.push_back(mk(4'b0100, 0, 28'hA10, 2, 1, 4'b0100, 2, 0, 1, 32'h20000A10, 0));
        tbl.push_back(mk(4'b0100, 0, 28'hA11, 2, 1, 4'b0100, 2, 1, 1, 32'h20000A11, 0));
        // Clean packet on ch0 after the mid-packet reset
        tbl.push_back(mk(4'b0001, 0, 28'hA20, 0, 1, 4'b0001, 0, 0, 1, 32'h00000A20, 0));
        tbl.push_back(mk(4'b0001, 1, 28'hA21, 0, 1, 4'b0001, 0, 1, 1, 32'h00000A21, 1));
        tbl.push_back(mk(4'b0000, 0, 28'h00, 0, 1, 4'b0001, 0, 0, 0, 32'h00000A21, 1));

        drive4(4'b0001, 1'b0, 28'h55);
        repeat (2) @(posedge clk);
        #1;
        chk("rst s_tready", 64'(s4.tready), 64'h0);
        chk("rst m_tvalid", 64'(m4.tvalid), 64'h0);
        chk("rst busy", 64'(busy4), 64'h0);
        chk("rst active_sel", 64'(act4), 64'h0);
        chk("rst m_tdata", 64'(m4.tdata), 64'h0);
        @(negedge clk);
        drive4(4'b0, 1'b0, 28'h0);
        reset = 1'b1;

        for (int i = 0; i < 33; i++) run(tbl[i], i);

        @(negedge clk);
        drive4(4'b0100, 1'b0, 28'hA12);
        #2 reset = 1'b0;
        #1;
        chk("midrst m_tvalid", 64'(m4.tvalid), 64'h0);
        chk("midrst m_tdata", 64'(m4.tdata), 64'h0);
        chk("midrst m_tlast", 64'(m4.tlast), 64'h0);
        chk("midrst busy", 64'(busy4), 64'h0);
        chk("midrst active_sel", 64'(act4), 64'h0);
        chk("midrst s_tready", 64'(s4.tready), 64'h0);
        @(posedge clk);
        #1;
        chk("midrst held m_tvalid", 64'(m4.tvalid), 64'h0);
        @(negedge clk);
        sel4 = 2'd0;
        drive4(4'b0, 1'b0, 28'h0);
        reset = 1'b1;

        for (int i = 33; i < tbl.size(); i++) run(tbl[i], i);

        // 3-channel mux: code 3 is out of range and must not move active_sel
        @(negedge clk);
        sel3 = 2'd0;
        drive3(3'b001, 28'h300);
        @(posedge clk);
        #1;
        chk("oor m_tvalid", 64'(m3.tvalid), 64'h1);
        chk("oor m_tdata0", 64'(m3.tdata), 64'h00000300);
        chk("oor sel_err0", 64'(err3), 64'h0);
        @(negedge clk);
        sel3 = 2'd3;
        drive3(3'b001, 28'h301);
        #1;
        chk("oor sel_err pre", 64'(err3), 64'h0);
        @(posedge clk);
        #1;
        chk("oor sel_err", 64'(err3), 64'h1);
        chk("oor active_sel", 64'(act3), 64'h0);
        chk("oor m_tdata1", 64'(m3.tdata), 64'h00000301);
        @(negedge clk);
        drive3(3'b001, 28'h302);
        #1;
        chk("oor s_tready", 64'(s3.tready), 64'h1);
        chk("oor active_sel held", 64'(act3), 64'h0);
        @(posedge clk);
        #1;
        chk("oor m_tdata2", 64'(m3.tdata), 64'h00000302);
        chk("oor sel_err held", 64'(err3), 64'h1);
        @(negedge clk);
        sel3 = 2'd1;
        drive3(3'b000, 28'h0);
        @(posedge clk);
        #1;
        chk("oor sel_err clear", 64'(err3), 64'h0);
        chk("oor m_tvalid drop", 64'(m3.tvalid), 64'h0);
        @(posedge clk);
        #1;
        chk("oor switch to 1", 64'(act3), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_mux_pkt.md
Name: axis_mux_pkt

Overview:
- Parametrised N-input to 1-output AXI-Stream multiplexer for the RFSoC sample/waveform datapath. It is the successor to the fixed 2-input, 256-bit selector.
- Channel switches happen only on packet boundaries, tracked via tlast, so a packet is never split across sources.
- Output is a registered, full-throughput pipeline stage with proper backpressure.
- Sits between multiple waveform/DMA sources and a single DAC-side stream consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 256, tdata width in bits.
- SEL_W, $clog2(NUM_CH), select width (derived; do not override).

Ports:
- clk, in, 1, stream clock.
- reset, in, 1, asynchronous, active-low reset.
- s_axis_tvalid, in, NUM_CH, per-channel valid.
- s_axis_tready, out, NUM_CH, per-channel ready.
- s_axis_tdata, in, NUM_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tlast, in, NUM_CH, per-channel end-of-packet.
- sel_in, in, SEL_W, requested channel (level, may change any time).
- m_axis_tdata, out, DATA_W, output data (registered).
- m_axis_tvalid, out, 1, output valid (registered).
- m_axis_tlast, out, 1, output last (registered).
- m_axis_tready, in, 1, downstream ready.
- active_sel, out, SEL_W, channel currently routed.
- busy, out, 1, high while a packet is in progress.
- sel_err, out, 1, high while registered request is >= NUM_CH.

Behaviour:
- Reset (reset=0, async): sel_q=0, active_sel=0, state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. Consequently busy=0 and all s_axis_tready=0 while in reset.
- sel_q <= sel_in every clk. This adds 1 cycle of request latency and is the only register on sel_in.
- sel_err = (sel_q >= NUM_CH), combinational from sel_q. An out-of-range request is ignored and active_sel is held.
- load_en = !m_axis_tvalid || m_axis_tready.
- switch = (state==IDLE) && (sel_q != active_sel) && !sel_err.
- s_axis_tready[i] = (i==active_sel) && load_en && !switch. Every non-active channel sees ready=0.
- Accept = s_axis_tvalid[active_sel] && s_axis_tready[active_sel].
- On accept, the output register loads tdata/tlast and m_axis_tvalid <= 1.
- Else, if m_axis_tready=1, m_axis_tvalid <= 0. Data/tlast hold when not loading.
- Input-to-output latency is 1 cycle. Sustained throughput is 1 beat/cycle with m_axis_tready=1.
- State machine (IDLE, PKT):
  - IDLE, switch=1: active_sel <= sel_q, stay IDLE. This is a 1-cycle bubble: no accept this cycle.
  - IDLE, accept with tlast=0: go to PKT.
  - IDLE, accept with tlast=1: stay IDLE (single-beat packet).
  - PKT, accept with tlast=1: go to IDLE.
  - PKT, any other case: stay PKT. sel_q changes are ignored; the switch is deferred until the return to IDLE.
- busy = (state==PKT).
- Switch after tlast: earliest new-channel accept is 2 cycles after the tlast accept (1 cycle to return to IDLE, 1 switch bubble).
- Stalled active channel (tvalid=0) in PKT keeps the mux locked. There is no timeout.
- Downstream stall: m_axis_tvalid and data hold stable until m_axis_tready=1. AXIS stability rules are met.
- Reset asserted mid-packet: output is discarded, state returns to IDLE, and active_sel returns to 0. The partial packet is not completed.
- NUM_CH not a power of two: codes NUM_CH..2^SEL_W-1 assert sel_err.

Test Plan:
- Reset/basic: after reset, sel_in=0, ch0 sends 4 beats D0..D3 (tlast on D3), m_tready=1 → m_axis output D0..D3 each 1 cycle after accept, m_tlast with D3, s_axis_tready[3:1]=0 throughout.
- Deferred switch: ch0 sends 8-beat packet; sel_in=2 driven at beat 3 → active_sel stays 0, busy=1 until beat 7 accepted. Then active_sel=2 one cycle later, and the first ch2 beat is accepted 2 cycles after beat 7.
- Backpressure: ch1 active, m_tready toggles 1,0,0,1 with continuous valid input → no beat lost or duplicated, m_tdata stable during the 0 cycles, s_axis_tready[1] low only when the output register is full and stalled.
- Idle switch bubble: busy=0, active_sel=0, sel_in changes 0→3 → active_sel=3 two cycles later, with all s_tready=0 during the switch cycle.
- Out-of-range select (NUM_CH=3): sel_in=3 → sel_err=1 one cycle later, active_sel unchanged, traffic on the current channel continues.
- Reset mid-packet: reset pulsed low during beat 2 of 5 on ch2 → m_tvalid=0, busy=0, active_sel=0 immediately (asynchronous), and clean operation on the next packet.
